// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light controller slice.
// Holds the light encodings, the farm-sensor FSM state codes and the default parameter values.
package tlc_pkg;

   typedef enum logic [1:0] {
      Red    = 2'd0,
      Yellow = 2'd1,
      Green  = 2'd2
   } light_t;

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StRiseChk = 2'd1;
   localparam logic [1:0] StPresent = 2'd2;
   localparam logic [1:0] StFallChk = 2'd3;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 8;
   localparam int unsigned DEF_SERVICE_CYCLES  = 16;
   localparam int unsigned DEF_CNT_W           = 4;

   // A vehicle counts as present until a departure has been fully debounced.
   function automatic logic vehicle_present(input logic [1:0] st);
      return (st == StPresent) || (st == StFallChk);
   endfunction

endpackage

// File: rtl/tlc_sync2.sv
// Generic two-flop synchronizer with a configurable reset value.
// Use it for any asynchronous level input entering the clk domain.
module tlc_sync2 #(
   parameter int unsigned     Width    = 1,
   parameter logic [Width-1:0] ResetVal = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [Width-1:0] d,
   output logic [Width-1:0] q
);

   logic [Width-1:0] s1_q;
   logic [Width-1:0] s2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= ResetVal;
         s2_q <= ResetVal;
      end else begin
         s1_q <= d;
         s2_q <= s1_q;
      end
   end

   assign q = s2_q;

endmodule

// File: rtl/farm_sensor_conditioner.sv
// Farm-road detector front end: synchronize, debounce, and keep a saturating queue count
// that drains at a fixed rate while the farm road has green.
module farm_sensor_conditioner
   import tlc_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned SERVICE_CYCLES  = DEF_SERVICE_CYCLES,
   parameter int unsigned CNT_W           = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sensor_raw,
   input  logic             farm_green,
   output logic             sensor,
   output logic             arrival_pulse,
   output logic [CNT_W-1:0] veh_count,
   output logic             overflow
);

   localparam int unsigned DcntW = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned TmrW  = (SERVICE_CYCLES > 1) ? $clog2(SERVICE_CYCLES) : 1;

   localparam logic [DcntW-1:0] DcntLast = DcntW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TmrW-1:0]  TmrLast  = TmrW'(SERVICE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CntMax   = '1;

   logic             s2;
   logic [1:0]       state_q, state_d;
   logic [DcntW-1:0] dcnt_q, dcnt_d;
   logic [TmrW-1:0]  tmr_q, tmr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             sensor_q, sensor_d;
   logic             pulse_q;
   logic             arrival;
   logic             svc_active;
   logic             dec;

   tlc_sync2 #(
      .Width    (1),
      .ResetVal (1'b0)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (sensor_raw),
      .q   (s2)
   );

   always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      arrival = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (s2) begin
               state_d = StRiseChk;
               dcnt_d  = DcntW'(1);
            end
         end
         StRiseChk: begin
            if (!s2) begin
               state_d = StIdle;
               dcnt_d  = '0;
            end else if (dcnt_q == DcntLast) begin
               state_d = StPresent;
               dcnt_d  = '0;
               arrival = 1'b1;
            end else begin
               dcnt_d = dcnt_q + DcntW'(1);
            end
         end
         StPresent: begin
            if (!s2) begin
               state_d = StFallChk;
               dcnt_d  = DcntW'(1);
            end
         end
         StFallChk: begin
            if (s2) begin
               state_d = StPresent;
               dcnt_d  = '0;
            end else if (dcnt_q == DcntLast) begin
               state_d = StIdle;
               dcnt_d  = '0;
            end else begin
               dcnt_d = dcnt_q + DcntW'(1);
            end
         end
      endcase
   end

   // Partial service intervals are discarded whenever green drops or the queue empties.
   assign svc_active = farm_green && (cnt_q != '0);
   assign dec        = svc_active && (tmr_q == TmrLast);

   always_comb begin
      tmr_d = '0;
      if (svc_active && (tmr_q != TmrLast)) begin
         tmr_d = tmr_q + TmrW'(1);
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (arrival && !dec) begin
         if (cnt_q == CntMax) begin
            ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (dec && !arrival) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   assign sensor_d = vehicle_present(state_d) || (cnt_d != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         dcnt_q   <= '0;
         tmr_q    <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         sensor_q <= 1'b0;
         pulse_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         dcnt_q   <= dcnt_d;
         tmr_q    <= tmr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         sensor_q <= sensor_d;
         pulse_q  <= arrival;
      end
   end

   assign sensor        = sensor_q;
   assign arrival_pulse = pulse_q;
   assign veh_count     = cnt_q;
   assign overflow      = ovf_q;

endmodule
